// File: rtl/gshare_btb_predictor.sv
// Gshare direction predictor with a direct-mapped branch target buffer.
// Lookup is purely combinational; training, BTB fill and history recovery commit on posedge.
module gshare_btb_predictor #(
    parameter int XLEN         = 32,
    parameter int GHR_BITS     = 8,
    parameter int CTR_BITS     = 2,
    parameter int BTB_IDX_BITS = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                lookup_valid,
    input  logic [XLEN-1:0]     lookup_pc,
    output logic                pred_hit,
    output logic                pred_taken,
    output logic [XLEN-1:0]     pred_target,
    output logic [GHR_BITS-1:0] pred_ghr,
    input  logic                update_valid,
    input  logic [XLEN-1:0]     update_pc,
    input  logic [GHR_BITS-1:0] update_ghr,
    input  logic                update_taken,
    input  logic [XLEN-1:0]     update_target,
    input  logic                update_mispredict,
    output logic [31:0]         mispredict_count
);

    localparam int PHT_N = 1 << GHR_BITS;
    localparam int BTB_N = 1 << BTB_IDX_BITS;
    localparam int TAG_W = XLEN - BTB_IDX_BITS - 2;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};

    logic [CTR_BITS-1:0] pht_q     [PHT_N];
    logic [CTR_BITS-1:0] pht_d;
    logic [BTB_N-1:0]    btb_vld_q;
    logic [TAG_W-1:0]    btb_tag_q [BTB_N];
    logic [XLEN-1:0]     btb_tgt_q [BTB_N];
    logic [GHR_BITS-1:0] ghr_q, ghr_d;
    logic [31:0]         cnt_q, cnt_d;

    logic [GHR_BITS-1:0]     lk_pht_idx, up_pht_idx;
    logic [BTB_IDX_BITS-1:0] lk_btb_idx, up_btb_idx;
    logic [TAG_W-1:0]        lk_tag, up_tag;
    logic                    recover, btb_we;
    logic                    unused_pc_bits;

    assign unused_pc_bits = ^{lookup_pc[1:0], update_pc[1:0]};

    assign lk_pht_idx = lookup_pc[GHR_BITS+1:2] ^ ghr_q;
    assign lk_btb_idx = lookup_pc[BTB_IDX_BITS+1:2];
    assign lk_tag     = lookup_pc[XLEN-1:BTB_IDX_BITS+2];

    assign up_pht_idx = update_pc[GHR_BITS+1:2] ^ update_ghr;
    assign up_btb_idx = update_pc[BTB_IDX_BITS+1:2];
    assign up_tag     = update_pc[XLEN-1:BTB_IDX_BITS+2];

    // Mispredict without a valid update carries no information and is dropped.
    assign recover = update_valid && update_mispredict;
    assign btb_we  = update_valid && update_taken;

    // Reads see register contents, so a same-cycle write is visible only after the edge.
    assign pred_hit    = btb_vld_q[lk_btb_idx] && (btb_tag_q[lk_btb_idx] == lk_tag);
    assign pred_taken  = pred_hit && pht_q[lk_pht_idx][CTR_BITS-1];
    assign pred_target = btb_tgt_q[lk_btb_idx];
    assign pred_ghr    = ghr_q;

    always_comb begin
        pht_d = pht_q[up_pht_idx];
        if (update_taken) begin
            if (pht_d != CTR_MAX) pht_d = pht_d + CTR_BITS'(1);
        end else begin
            if (pht_d != '0) pht_d = pht_d - CTR_BITS'(1);
        end
    end

    // Recovery from the resolved branch outranks any speculative shift in the same cycle.
    always_comb begin
        ghr_d = ghr_q;
        if (recover) begin
            ghr_d = {update_ghr[GHR_BITS-2:0], update_taken};
        end else if (lookup_valid && pred_hit) begin
            ghr_d = {ghr_q[GHR_BITS-2:0], pred_taken};
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (recover && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ghr_q <= '0;
            cnt_q <= '0;
        end else begin
            ghr_q <= ghr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < PHT_N; i++) pht_q[i] <= CTR_INIT;
        end else if (update_valid) begin
            pht_q[up_pht_idx] <= pht_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btb_vld_q <= '0;
        end else if (btb_we) begin
            btb_vld_q[up_btb_idx] <= 1'b1;
        end
    end

    // Tag and target payload need no reset: a cleared valid bit masks them.
    always_ff @(posedge clk) begin
        if (btb_we) begin
            btb_tag_q[up_btb_idx] <= up_tag;
            btb_tgt_q[up_btb_idx] <= update_target;
        end
    end

    assign mispredict_count = cnt_q;

endmodule

// File: tb/tb_gshare_btb_predictor.sv
// Directed bench for gshare_btb_predictor using hand-computed expectations.
module tb_gshare_btb_predictor;

    logic        clk;
    logic        reset_n;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [7:0]  pred_ghr;
    logic        update_valid;
    logic [31:0] update_pc;
    logic [7:0]  update_ghr;
    logic        update_taken;
    logic [31:0] update_target;
    logic        update_mispredict;
    logic [31:0] mispredict_count;

    int total;
    int bad;

    gshare_btb_predictor #(
        .XLEN(32), .GHR_BITS(8), .CTR_BITS(2), .BTB_IDX_BITS(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .lookup_valid(lookup_valid),
        .lookup_pc(lookup_pc),
        .pred_hit(pred_hit),
        .pred_taken(pred_taken),
        .pred_target(pred_target),
        .pred_ghr(pred_ghr),
        .update_valid(update_valid),
        .update_pc(update_pc),
        .update_ghr(update_ghr),
        .update_taken(update_taken),
        .update_target(update_target),
        .update_mispredict(update_mispredict),
        .mispredict_count(mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_update();
        update_valid      = 1'b0;
        update_mispredict = 1'b0;
        update_taken      = 1'b0;
        update_pc         = '0;
        update_ghr        = '0;
        update_target     = '0;
    endtask

    task automatic train(input logic [31:0] pc, input logic [7:0] g,
                         input logic tk, input logic [31:0] tgt);
        update_valid      = 1'b1;
        update_mispredict = 1'b0;
        update_pc         = pc;
        update_ghr        = g;
        update_taken      = tk;
        update_target     = tgt;
        tick();
        clear_update();
    endtask

    task automatic test_reset();
        lookup_valid = 1'b1;
        lookup_pc    = 32'h100;
        #1;
        total++; if (pred_hit !== 1'b0) begin bad++; $display("FAIL cold_hit got=%b want=0", pred_hit); end
        total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL cold_taken got=%b want=0", pred_taken); end
        total++; if (pred_ghr !== 8'h00) begin bad++; $display("FAIL cold_ghr got=%h want=00", pred_ghr); end
        total++; if (mispredict_count !== 32'd0) begin bad++; $display("FAIL cold_cnt got=%0d want=0", mispredict_count); end
        lookup_valid = 1'b0;
    endtask

    task automatic test_train();
        train(32'h100, 8'h00, 1'b1, 32'h80);
        train(32'h100, 8'h00, 1'b1, 32'h80);
        lookup_valid = 1'b1;
        lookup_pc    = 32'h100;
        #1;
        total++; if (pred_hit !== 1'b1) begin bad++; $display("FAIL train_hit got=%b want=1", pred_hit); end
        total++; if (pred_target !== 32'h80) begin bad++; $display("FAIL train_target got=%h want=00000080", pred_target); end
        total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL train_taken got=%b want=1", pred_taken); end
        total++; if (pred_ghr !== 8'h00) begin bad++; $display("FAIL train_ghr_pre got=%h want=00", pred_ghr); end
        tick();
        lookup_valid = 1'b0;
        total++; if (pred_ghr !== 8'h01) begin bad++; $display("FAIL train_ghr_shift got=%h want=01", pred_ghr); end
    endtask

    task automatic test_alias();
        lookup_pc = 32'h140;
        #1;
        total++; if (pred_hit !== 1'b0) begin bad++; $display("FAIL alias_hit got=%b want=0", pred_hit); end
        total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL alias_taken got=%b want=0", pred_taken); end
        lookup_pc = 32'h100;
        #1;
        total++; if (pred_hit !== 1'b1) begin bad++; $display("FAIL alias_orig_hit got=%b want=1", pred_hit); end
    endtask

    task automatic test_recovery();
        // Bring history back to zero via a plain recovery.
        update_valid = 1'b1; update_mispredict = 1'b1; update_pc = 32'h400;
        update_ghr = 8'h00; update_taken = 1'b0; update_target = '0;
        tick();
        clear_update();
        total++; if (pred_ghr !== 8'h00) begin bad++; $display("FAIL rec_zero_ghr got=%h want=00", pred_ghr); end
        total++; if (mispredict_count !== 32'd1) begin bad++; $display("FAIL rec_cnt1 got=%0d want=1", mispredict_count); end
        // Speculative hit (taken) and recovery in the same cycle.
        lookup_valid = 1'b1; lookup_pc = 32'h100;
        update_valid = 1'b1; update_mispredict = 1'b1; update_pc = 32'h400;
        update_ghr = 8'hA5; update_taken = 1'b0;
        #1;
        total++; if ({pred_hit, pred_taken} !== 2'b11) begin bad++; $display("FAIL rec_spec_pred got=%b want=11", {pred_hit, pred_taken}); end
        tick();
        clear_update();
        lookup_valid = 1'b0;
        total++; if (pred_ghr !== 8'h4A) begin bad++; $display("FAIL rec_priority_ghr got=%h want=4a", pred_ghr); end
        total++; if (mispredict_count !== 32'd2) begin bad++; $display("FAIL rec_cnt2 got=%0d want=2", mispredict_count); end
        // Mispredict without update_valid is ignored.
        update_mispredict = 1'b1; update_ghr = 8'hFF; update_taken = 1'b1;
        tick();
        clear_update();
        total++; if (mispredict_count !== 32'd2) begin bad++; $display("FAIL rec_ignored_cnt got=%0d want=2", mispredict_count); end
        total++; if (pred_ghr !== 8'h4A) begin bad++; $display("FAIL rec_ignored_ghr got=%h want=4a", pred_ghr); end
        // A lookup that misses leaves history alone.
        lookup_valid = 1'b1; lookup_pc = 32'h500;
        tick();
        lookup_valid = 1'b0;
        total++; if (pred_ghr !== 8'h4A) begin bad++; $display("FAIL miss_hold_ghr got=%h want=4a", pred_ghr); end
    endtask

    task automatic test_same_cycle();
        lookup_valid = 1'b0; lookup_pc = 32'h140;
        update_valid = 1'b1; update_mispredict = 1'b0; update_pc = 32'h140;
        update_ghr = 8'h4A; update_taken = 1'b1; update_target = 32'h300;
        #1;
        total++; if (pred_hit !== 1'b0) begin bad++; $display("FAIL same_old_hit got=%b want=0", pred_hit); end
        tick();
        clear_update();
        total++; if (pred_hit !== 1'b1) begin bad++; $display("FAIL same_new_hit got=%b want=1", pred_hit); end
        total++; if (pred_target !== 32'h300) begin bad++; $display("FAIL same_new_target got=%h want=00000300", pred_target); end
        total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL same_new_taken got=%b want=1", pred_taken); end
        lookup_pc = 32'h100;
        #1;
        total++; if (pred_hit !== 1'b0) begin bad++; $display("FAIL same_evict_hit got=%b want=0", pred_hit); end
    endtask

    task automatic test_saturation();
        lookup_valid = 1'b0; lookup_pc = 32'h200;
        for (int i = 0; i < 5; i++) train(32'h200, 8'h4A, 1'b1, 32'h2000);
        #1;
        total++; if (pred_hit !== 1'b1) begin bad++; $display("FAIL sat_hit got=%b want=1", pred_hit); end
        total++; if (pred_target !== 32'h2000) begin bad++; $display("FAIL sat_target got=%h want=00002000", pred_target); end
        total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL sat_top got=%b want=1", pred_taken); end
        train(32'h200, 8'h4A, 1'b0, 32'h0);
        total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL sat_top_minus1 got=%b want=1", pred_taken); end
        train(32'h200, 8'h4A, 1'b1, 32'h2000);
        for (int i = 0; i < 5; i++) train(32'h200, 8'h4A, 1'b0, 32'h0);
        total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL sat_bottom got=%b want=0", pred_taken); end
        total++; if (pred_hit !== 1'b1) begin bad++; $display("FAIL sat_nt_keeps_btb got=%b want=1", pred_hit); end
        train(32'h200, 8'h4A, 1'b0, 32'h0);
        train(32'h200, 8'h4A, 1'b1, 32'h2000);
        total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL sat_bottom_plus1 got=%b want=0", pred_taken); end
        train(32'h200, 8'h4A, 1'b1, 32'h2000);
        total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL sat_bottom_plus2 got=%b want=1", pred_taken); end
    endtask

    task automatic test_async_reset();
        lookup_valid = 1'b0; lookup_pc = 32'h200;
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        total++; if (pred_hit !== 1'b0) begin bad++; $display("FAIL arst_hit got=%b want=0", pred_hit); end
        total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL arst_taken got=%b want=0", pred_taken); end
        total++; if (mispredict_count !== 32'd0) begin bad++; $display("FAIL arst_cnt got=%0d want=0", mispredict_count); end
        total++; if (pred_ghr !== 8'h00) begin bad++; $display("FAIL arst_ghr got=%h want=00", pred_ghr); end
        tick();
        reset_n = 1'b1;
        lookup_valid = 1'b1; lookup_pc = 32'h300;
        tick();
        lookup_valid = 1'b0;
        total++; if (pred_ghr !== 8'h00) begin bad++; $display("FAIL post_rst_ghr got=%h want=00", pred_ghr); end
        lookup_pc = 32'h200;
        #1;
        total++; if (pred_hit !== 1'b0) begin bad++; $display("FAIL post_rst_hit got=%b want=0", pred_hit); end
        // Counter at reset value (weakly not-taken): one taken update makes it predict taken.
        train(32'h200, 8'h00, 1'b1, 32'h2000);
        total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL post_rst_ctr got=%b want=1", pred_taken); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset_n      = 1'b0;
        lookup_valid = 1'b0;
        lookup_pc    = '0;
        clear_update();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        test_reset();
        test_train();
        test_alias();
        test_recovery();
        test_same_cycle();
        test_saturation();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
